multi_port_register_file: RTL and testbench
===========================================

// Module: multi_port_register_file
//
// PURPOSE
//  Parametrised general-purpose register file for the multi-issue pipeline core.
//  - Generalises width, register count, read-port count and write-port count.
//  - Keeps a per-register pending (scoreboard) bit: issue sets it, writeback clears it.
//  - Sits between decode/issue (reads, reservations) and writeback (writes).
//
// PARAMETERS
//  DATA_WIDTH   32  bits per register
//  REG_COUNT    32  number of registers; power of two, >= 2
//  READ_PORTS    2  independent combinational read ports, >= 1
//  WRITE_PORTS   2  independent synchronous write ports, >= 1
//  ID_WIDTH     $clog2(REG_COUNT)  localparam, not overridable
//
// PORTS
//  clock           in   1                      rising-edge clock
//  reset           in   1                      synchronous, active-high
//  readId          in   READ_PORTS*ID_WIDTH    register id, port r = slice r
//  readData        out  READ_PORTS*DATA_WIDTH  register value per port
//  readBusy        out  READ_PORTS             pending bit of readId per port
//  writeEnabled    in   WRITE_PORTS            write strobe per port
//  writeId         in   WRITE_PORTS*ID_WIDTH   destination per port
//  writeData       in   WRITE_PORTS*DATA_WIDTH data per port
//  reserveEnabled  in   1                      mark reserveId pending
//  reserveId       in   ID_WIDTH               register being issued
//  pendingCount    out  ID_WIDTH+1             number of pending registers
//
// BEHAVIOUR
//  Storage and pending bits
//  - All storage and pending bits update on the rising edge of clock only.
//  - Reset: every register = 0, every pending bit = 0, pendingCount = 0.
//  - Reset overrides all writes and reservations in that cycle.
//  - Register 0: reads always return 0 and readBusy = 0.
//  - Register 0: writes and reservations to it are discarded.
//  Writes
//  - When writeEnabled[w] && writeId[w] != 0, the register takes writeData[w] at the edge.
//  - The same edge clears that register's pending bit.
//  - Two ports writing the same id in one cycle: the highest-numbered port wins.
//  Reservations
//  - reserveEnabled && reserveId != 0 sets that register's pending bit at the edge.
//  - Reserve and write to the same id in the same cycle: data is written and pending ends SET.
//    The new producer wins.
//  - Reserving an already-pending register keeps it pending; there is no counting.
//  Reads
//  - readData and readBusy are combinational from readId; latency is 0 cycles.
//  - Values come from the current state (see CONFIGURATION for same-cycle writes).
//  pendingCount
//  - Registered population count of the pending bits; valid from the cycle after each edge.
//  - Never exceeds REG_COUNT-1.
//  - Out-of-range ids cannot occur: ID_WIDTH covers REG_COUNT exactly.
//
// CONFIGURATION
//  REGFILE_BYPASS_EN defined
//  - A read whose id matches an enabled same-cycle write (id != 0) returns that writeData.
//    The highest-numbered matching port wins.
//  - readBusy for that port = 0, unless reserveEnabled targets the same id that cycle.
//  - Lets writeback and decode share a cycle without a stall.
//  REGFILE_BYPASS_EN undefined
//  - Reads return stored state only.
//  - A same-cycle write is visible one cycle later.
//  - readBusy stays 1 until after the clearing edge.
//
// TESTING
//  - Reset: assert reset 2 cycles after random writes -> every readData = 0,
//    readBusy = 0, pendingCount = 0.
//  - Zero register: write port 0 id 0 data 32'hDEADBEEF, reserve id 0
//    -> reading id 0 gives 0, busy 0, pendingCount 0.
//  - Write collision: ports 0 and 1 both write id 5 with 32'h11 and 32'h22
//    -> next cycle id 5 reads 32'h22.
//  - Scoreboard: reserve id 7; next cycle readBusy = 1, pendingCount = 1.
//    Then write id 7 with 32'hA5 -> next cycle busy 0, data 32'hA5, count 0.
//  - Reserve and write same cycle on id 9 (data 32'h33) -> next cycle data 32'h33,
//    busy 1, count 1.
//  - Bypass: write id 3 with 32'h77 while reading id 3 -> with REGFILE_BYPASS_EN,
//    readData = 32'h77 that cycle; without it, old value that cycle and 32'h77 the next.

Source files
------------

// File: rtl/multi_port_register_file.sv
// Multi-port register file with per-register pending bits for issue/writeback.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module multi_port_register_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_COUNT   = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    localparam int ID_WIDTH   = $clog2(REG_COUNT)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [READ_PORTS*ID_WIDTH-1:0]    readId,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  readData,
    output logic [READ_PORTS-1:0]             readBusy,
    input  logic [WRITE_PORTS-1:0]            writeEnabled,
    input  logic [WRITE_PORTS*ID_WIDTH-1:0]   writeId,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] writeData,
    input  logic                              reserveEnabled,
    input  logic [ID_WIDTH-1:0]               reserveId,
    output logic [ID_WIDTH:0]                 pendingCount
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  pending;
    logic [REG_COUNT-1:0]  nextPending;
    logic [ID_WIDTH:0]     nextCount;

    // Writeback clears, then issue sets: a same-cycle reservation leaves the bit set.
    always_comb begin
        nextPending = pending;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (writeEnabled[w] && writeId[w*ID_WIDTH +: ID_WIDTH] != '0) begin
                nextPending[writeId[w*ID_WIDTH +: ID_WIDTH]] = 1'b0;
            end
        end
        if (reserveEnabled && reserveId != '0) begin
            nextPending[reserveId] = 1'b1;
        end
        nextPending[0] = 1'b0;
    end

    always_comb begin
        nextCount = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            nextCount = nextCount + {{ID_WIDTH{1'b0}}, nextPending[i]};
        end
    end

    // Later ports are assigned last, so the highest-numbered port wins a collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            pending      <= '0;
            pendingCount <= '0;
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (writeEnabled[w] && writeId[w*ID_WIDTH +: ID_WIDTH] != '0) begin
                    regs[writeId[w*ID_WIDTH +: ID_WIDTH]] <= writeData[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            pending      <= nextPending;
            pendingCount <= nextCount;
        end
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : gRead
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;

        assign id = readId[r*ID_WIDTH +: ID_WIDTH];

        always_comb begin
            data = regs[id];
            busy = pending[id];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (writeEnabled[w] && writeId[w*ID_WIDTH +: ID_WIDTH] == id) begin
                    data = writeData[w*DATA_WIDTH +: DATA_WIDTH];
                    busy = reserveEnabled && (reserveId == id);
                end
            end
`endif
            // Register 0 is hard-wired to zero and never pending.
            if (id == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign readData[r*DATA_WIDTH +: DATA_WIDTH] = data;
        assign readBusy[r] = busy;
    end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench for multi_port_register_file: array model checked every cycle
// plus literal expectations; honours REGFILE_BYPASS_EN like the design.
module tb_multi_port_register_file;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int IW = 5;
    localparam int RP = 2;
    localparam int WP = 2;

    logic              clock;
    logic              reset;
    logic [RP*IW-1:0]  readId;
    logic [RP*DW-1:0]  readData;
    logic [RP-1:0]     readBusy;
    logic [WP-1:0]     writeEnabled;
    logic [WP*IW-1:0]  writeId;
    logic [WP*DW-1:0]  writeData;
    logic              reserveEnabled;
    logic [IW-1:0]     reserveId;
    logic [IW:0]       pendingCount;

    int checks = 0;
    int failures = 0;

    multi_port_register_file dut (
        .clock(clock),
        .reset(reset),
        .readId(readId),
        .readData(readData),
        .readBusy(readBusy),
        .writeEnabled(writeEnabled),
        .writeId(writeId),
        .writeData(writeData),
        .reserveEnabled(reserveEnabled),
        .reserveId(reserveId),
        .pendingCount(pendingCount)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model ----------------
    logic [DW-1:0] mReg [RC];
    bit            mPend [RC];
    bit            modelReady = 0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RC; i++) begin
                mReg[i]  = '0;
                mPend[i] = 0;
            end
            modelReady = 1;
        end else begin
            for (int w = 0; w < WP; w++) begin
                if (writeEnabled[w] && writeId[w*IW +: IW] != 0) begin
                    mReg[writeId[w*IW +: IW]]  = writeData[w*DW +: DW];
                    mPend[writeId[w*IW +: IW]] = 0;
                end
            end
            if (reserveEnabled && reserveId != 0) mPend[reserveId] = 1;
        end
    end

    function automatic void modelRead(input logic [IW-1:0] id, output logic [DW-1:0] d,
                                      output logic b);
        d = mReg[id];
        b = mPend[id];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < WP; w++) begin
            if (writeEnabled[w] && writeId[w*IW +: IW] == id && id != 0) begin
                d = writeData[w*DW +: DW];
                b = reserveEnabled && reserveId == id;
            end
        end
`endif
        if (id == 0) begin
            d = '0;
            b = 0;
        end
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < RC; i++) n += int'(mPend[i]);
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    logic [DW-1:0] expData;
    logic          expBusy;

    always @(negedge clock) begin
        if (modelReady) begin
            for (int r = 0; r < RP; r++) begin
                modelRead(readId[r*IW +: IW], expData, expBusy);
                check("cmp_readData", 64'(readData[r*DW +: DW]), 64'(expData));
                check("cmp_readBusy", 64'(readBusy[r]), 64'(expBusy));
            end
            check("cmp_pendingCount", 64'(pendingCount), 64'(modelCount()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        writeEnabled   = '0;
        writeId        = '0;
        writeData      = '0;
        reserveEnabled = 1'b0;
        reserveId      = '0;
    endtask

    task automatic setRead(input int p, input logic [IW-1:0] id);
        readId[p*IW +: IW] = id;
    endtask

    task automatic setWrite(input int p, input logic [IW-1:0] id, input logic [DW-1:0] d);
        writeEnabled[p]        = 1'b1;
        writeId[p*IW +: IW]    = id;
        writeData[p*DW +: DW]  = d;
    endtask

    task automatic setReserve(input logic [IW-1:0] id);
        reserveEnabled = 1'b1;
        reserveId      = id;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset  = 1'b1;
        readId = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        check("reset_count", 64'(pendingCount), 64'd0);

        // Random traffic, then reset two cycles later.
        for (int c = 0; c < 6; c++) begin
            idle();
            for (int w = 0; w < WP; w++) begin
                if ($urandom_range(0, 1) == 1)
                    setWrite(w, IW'($urandom_range(0, RC - 1)), $urandom);
            end
            if ($urandom_range(0, 1) == 1) setReserve(IW'($urandom_range(0, RC - 1)));
            tick();
        end
        idle();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < RC; i++) begin
            setRead(0, IW'(i));
            setRead(1, IW'(RC - 1 - i));
            #1;
            check("reset_data0", 64'(readData[0 +: DW]), 64'd0);
            check("reset_data1", 64'(readData[DW +: DW]), 64'd0);
            check("reset_busy", 64'(readBusy), 64'd0);
            check("reset_pcount", 64'(pendingCount), 64'd0);
        end
        tick();

        // Register 0 ignores writes and reservations.
        setRead(0, 0);
        setWrite(0, 0, 32'hDEADBEEF);
        setReserve(0);
        tick();
        idle();
        #2;
        check("zero_data", 64'(readData[0 +: DW]), 64'd0);
        check("zero_busy", 64'(readBusy[0]), 64'd0);
        check("zero_count", 64'(pendingCount), 64'd0);

        // Write collision: port 1 wins.
        setWrite(0, 5, 32'h11);
        setWrite(1, 5, 32'h22);
        tick();
        idle();
        setRead(0, 5);
        #2;
        check("collide_data", 64'(readData[0 +: DW]), 64'h22);

        // Scoreboard reserve then clear.
        setReserve(7);
        tick();
        idle();
        setRead(0, 7);
        #2;
        check("reserve_busy", 64'(readBusy[0]), 64'd1);
        check("reserve_count", 64'(pendingCount), 64'd1);
        setWrite(0, 7, 32'hA5);
        tick();
        idle();
        #2;
        check("clear_busy", 64'(readBusy[0]), 64'd0);
        check("clear_data", 64'(readData[0 +: DW]), 64'hA5);
        check("clear_count", 64'(pendingCount), 64'd0);

        // Reserve and write together: data lands, pending stays set.
        setWrite(1, 9, 32'h33);
        setReserve(9);
        tick();
        idle();
        setRead(1, 9);
        #2;
        check("rsvwr_data", 64'(readData[DW +: DW]), 64'h33);
        check("rsvwr_busy", 64'(readBusy[1]), 64'd1);
        check("rsvwr_count", 64'(pendingCount), 64'd1);

        // Same-cycle read of a write.
        setRead(0, 3);
        setWrite(0, 3, 32'h77);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", 64'(readData[0 +: DW]), 64'h77);
`else
        check("bypass_same", 64'(readData[0 +: DW]), 64'h0);
`endif
        tick();
        idle();
        #2;
        check("bypass_next", 64'(readData[0 +: DW]), 64'h77);

        // Busy while the clearing write is in flight.
        setReserve(4);
        tick();
        idle();
        setRead(1, 4);
        setWrite(1, 4, 32'h44);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("inflight_busy", 64'(readBusy[1]), 64'd0);
        check("inflight_data", 64'(readData[DW +: DW]), 64'h44);
`else
        check("inflight_busy", 64'(readBusy[1]), 64'd1);
        check("inflight_data", 64'(readData[DW +: DW]), 64'h0);
`endif
        tick();
        idle();
        #2;
        check("after_busy", 64'(readBusy[1]), 64'd0);
        check("after_data", 64'(readData[DW +: DW]), 64'h44);
        check("after_count", 64'(pendingCount), 64'd1);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
